// File: rtl/control_pipe_if.sv
// Fetch/hazard-side handshake and per-stage control taps of the WISC-S25 control pipe.
// The fetch side drives instr/instr_valid/stall/flush; the pipe drives the rest.
interface control_pipe_if #(
  parameter int unsigned NSTG  = 3,
  parameter int unsigned CNT_W = 16
);
  localparam int unsigned CW = 18;

  logic [15:0]          instr;
  logic                 instr_valid;
  logic                 stall;
  logic                 flush;
  logic                 ready;
  logic [NSTG*CW-1:0]   ctrl_stg;
  logic [NSTG-1:0]      valid_stg;
  logic                 halt_pending;
  logic                 halted;
  logic [CNT_W-1:0]     retired;

  modport master (
    output instr, instr_valid, stall, flush,
    input  ready, ctrl_stg, valid_stg, halt_pending, halted, retired
  );

  modport slave (
    input  instr, instr_valid, stall, flush,
    output ready, ctrl_stg, valid_stg, halt_pending, halted, retired
  );
endinterface

// File: rtl/control_pipe.sv
// Decodes WISC-S25 instructions into an 18-bit control word and carries it through
// NSTG registered stages with stall bubbles, branch flush, halt drain and a retire counter.
module control_pipe #(
  parameter int unsigned NSTG  = 3,
  parameter int unsigned CNT_W = 16
) (
  input  logic          clk,
  input  logic          rst,
  control_pipe_if.slave bus
);

  localparam int unsigned CW = 18;

  // Field order MSB first so that alu_op lands on bits [3:0].
  typedef struct packed {
    logic       flag_en;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic       branch;
    logic       branch_reg;
    logic       halt;
    logic       pcs;
    logic       mem_to_reg;
    logic       alu_src;
    logic       rr2_sel;
    logic       rr1_sel;
    logic [1:0] imm_sel;
    logic [3:0] alu_op;
  } ctrl_t;

  ctrl_t [NSTG-1:0]  ctrl_q, ctrl_d;
  logic  [NSTG-1:0]  valid_q, valid_d;
  logic              halted_q, halted_d;
  logic [CNT_W-1:0]  retired_q, retired_d;

  logic   halt_seen_c;
  logic   halt_pending_c;
  logic   ready_c;
  logic   accept_c;
  ctrl_t  dec_c;
  logic   unused_instr_c;

  function automatic ctrl_t decode(input logic [3:0] op);
    ctrl_t c;
    c            = '0;
    c.alu_op     = op;
    c.mem_write  = (op == 4'b1001);
    c.mem_read   = (op == 4'b1000);
    c.mem_to_reg = (op == 4'b1000);
    c.rr1_sel    = (op[3:1] == 3'b101);
    c.rr2_sel    = (op == 4'b1001);
    if (op[3:1] == 3'b101) begin
      c.imm_sel = 2'b10;
    end else if (op[3:1] == 3'b100) begin
      c.imm_sel = 2'b01;
    end else begin
      c.imm_sel = 2'b00;
    end
    c.alu_src    = (op == 4'b0100) | (op == 4'b0101) | (op == 4'b0110) | (op[3:2] == 2'b10);
    c.pcs        = (op == 4'b1110);
    c.halt       = (op == 4'b1111);
    c.branch     = (op == 4'b1100);
    c.branch_reg = (op == 4'b1101);
    c.reg_write  = ~op[3] | (op == 4'b1000) | (op == 4'b1010) | (op == 4'b1011) | (op == 4'b1110);
    c.flag_en    = (op == 4'b0000) | (op == 4'b0001) | (op == 4'b0010) |
                   (op == 4'b0100) | (op == 4'b0101) | (op == 4'b0110);
    return c;
  endfunction

  // Only the opcode nibble feeds the control word.
  assign unused_instr_c = ^bus.instr[11:0];
  assign dec_c          = decode(bus.instr[15:12]);

  // A valid HLT anywhere in the pipe blocks fetch until it retires or is flushed.
  always_comb begin
    halt_seen_c = 1'b0;
    for (int unsigned k = 0; k < NSTG; k++) begin
      halt_seen_c = halt_seen_c | (valid_q[k] & ctrl_q[k].halt);
    end
  end

  assign halt_pending_c = halt_seen_c & ~halted_q;
  assign ready_c        = ~bus.stall & ~halt_pending_c & ~halted_q;
  assign accept_c       = bus.instr_valid & ready_c & ~bus.flush;

  always_comb begin
    ctrl_d    = ctrl_q;
    valid_d   = valid_q;
    halted_d  = halted_q;
    retired_d = retired_q;

    // Stages 2 and beyond always advance, whatever stall or flush say.
    for (int unsigned k = 2; k < NSTG; k++) begin
      ctrl_d[k]  = ctrl_q[k-1];
      valid_d[k] = valid_q[k-1];
    end

    if (bus.flush) begin
      ctrl_d[0]  = '0;
      valid_d[0] = 1'b0;
      ctrl_d[1]  = '0;
      valid_d[1] = 1'b0;
    end else if (bus.stall) begin
      ctrl_d[1]  = '0;
      valid_d[1] = 1'b0;
    end else begin
      ctrl_d[0]  = accept_c ? dec_c : '0;
      valid_d[0] = accept_c;
      ctrl_d[1]  = ctrl_q[0];
      valid_d[1] = valid_q[0];
    end

    if (valid_q[NSTG-1]) begin
      if (retired_q != '1) begin
        retired_d = retired_q + CNT_W'(1);
      end
      if (ctrl_q[NSTG-1].halt) begin
        halted_d = 1'b1;
      end
    end

    // Once halted the pipe is frozen empty until reset.
    if (halted_q) begin
      ctrl_d    = '0;
      valid_d   = '0;
      retired_d = retired_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl_q    <= '0;
      valid_q   <= '0;
      halted_q  <= 1'b0;
      retired_q <= '0;
    end else begin
      ctrl_q    <= ctrl_d;
      valid_q   <= valid_d;
      halted_q  <= halted_d;
      retired_q <= retired_d;
    end
  end

  assign bus.ctrl_stg     = ctrl_q;
  assign bus.valid_stg    = valid_q;
  assign bus.halted       = halted_q;
  assign bus.retired      = retired_q;
  assign bus.halt_pending = halt_pending_c;
  assign bus.ready        = ready_c;

endmodule
